ahblite_busmatrix_outputstage_arb: RTL and testbench
====================================================

// Module: ahblite_busmatrix_outputstage_arb
// PURPOSE
//  Output-stage arbiter of the AHB-Lite bus matrix: shares one slave port (e.g. the SUB peripheral bus) between
//  3 matrix input stages (0=ICODE, 1=DCODE, 2=SYSTEM/DMA). It picks the address-phase owner, holds it across
//  slave wait states and bursts, tracks the data-phase owner for HWDATA steering, and returns per-input ACTIVE.
//  Slave HRESP/HRDATA go straight to the decoders and are not routed through this block.
// PARAMETERS
//  RR_EN    1  1 = round-robin arbitration; 0 = fixed priority (input 0 highest, then 1, then 2)
//  (input count is fixed at 3; address and data are 32-bit; fields of input r sit at slice r of each *_IN bus)
// PORTS
//  HCLK        in   1   clock
//  HRESETn     in   1   reset, asynchronous, active-low
//  HSEL_IN     in   3   decoder select for this output stage, one bit per input
//  HTRANS_IN   in   6   HTRANS per input, [2r+1:2r]
//  HADDR_IN    in   96  HADDR per input, [32r+31:32r]
//  HWRITE_IN   in   3   HWRITE per input
//  HSIZE_IN    in   9   HSIZE per input, [3r+2:3r]
//  HWDATA_IN   in   96  HWDATA per input
//  HREADYOUT_S in   1   HREADYOUT from the slave
//  HSEL_OUT    out  1   slave select
//  HTRANS_OUT  out  2   muxed HTRANS (IDLE when no owner)
//  HADDR_OUT   out  32  muxed HADDR
//  HWRITE_OUT  out  1   muxed HWRITE
//  HSIZE_OUT   out  3   muxed HSIZE
//  HWDATA_OUT  out  32  HWDATA of the data-phase owner
//  HREADY_OUT  out  1   HREADY to the slave, = HREADYOUT_S
//  ACTIVE_OUT  out  3   one-hot: input r owns the address phase this cycle
// BEHAVIOUR
//  - req[r] = HSEL_IN[r] & HTRANS_IN[r][1] (NONSEQ/SEQ).
//  - Registers: own_q[1:0] and own_vld_q (last address-phase owner), hold_q (address phase stalled),
//    last_q[1:0] (round-robin pointer), dph_q[1:0] and dph_vld_q (data-phase owner).
//  - Address owner this cycle, in priority order:
//    a) hold_q=1 -> own_q, unchanged.
//    b) burst lock: own_vld_q and HSEL_IN[own_q] and HTRANS_IN[own_q] is BUSY or SEQ -> own_q.
//    c) arbitration: RR_EN=1 -> first req[r] scanning last_q+1, last_q+2, last_q+3 (mod 3).
//       RR_EN=0 -> lowest-index req.
//    d) otherwise no owner: HSEL_OUT=0, HTRANS_OUT=IDLE, HADDR/HWRITE/HSIZE_OUT=0, ACTIVE_OUT=0.
//  - With an owner o: HSEL_OUT=1; HTRANS/HADDR/HWRITE/HSIZE_OUT come from input o; ACTIVE_OUT = 1<<o.
//    ACTIVE_OUT is combinational, so each decoder sees it in the same cycle.
//  - Every clock: own_q <= o; own_vld_q <= owner exists; hold_q <= owner exists & ~HREADYOUT_S.
//    last_q <= o only when a new grant is made through case (c).
//  - When HREADYOUT_S=1: dph_vld_q <= owner exists & HTRANS_OUT[1]; dph_q <= o.
//    When HREADYOUT_S=0, both hold their values.
//  - HWDATA_OUT = dph_vld_q ? HWDATA_IN[dph_q] : 0.
//  - A wait state freezes the owner and the address fields for as many cycles as HREADYOUT_S stays 0.
//    Requests that are not granted stay pending in their input stages with ACTIVE_OUT[r]=0.
//  - Reset, including mid-transfer: all registers clear and last_q=2, so input 0 wins first.
//    Outputs then show no owner until a new req arrives; zero-latency grant on the same cycle.
//  - Simultaneous requests from all 3 inputs, steady, RR_EN=1: grants rotate 0,1,2,0 per single transfer.
// TESTING
//  T1 reset: HRESETn=0 with req=3'b111 -> HSEL_OUT=0, ACTIVE_OUT=0, HWDATA_OUT=0.
//     First cycle after release: ACTIVE_OUT=3'b001.
//  T2 round-robin: all 3 inputs issue NONSEQ singles, HREADYOUT_S=1 -> ACTIVE_OUT sequence 001,010,100,001.
//     RR_EN=0 -> stays 001.
//  T3 wait state: input 1 issues NONSEQ HADDR=0x40000104, HREADYOUT_S=0 for 3 cycles while input 0 requests
//     -> HADDR_OUT stays 0x40000104 and ACTIVE_OUT stays 010 for all 4 cycles.
//  T4 burst lock: input 2 issues NONSEQ,SEQ,BUSY,SEQ while input 0 requests -> input 2 holds the grant
//     for all 4 beats; input 0 is granted on the next cycle.
//  T5 HWDATA steering: input 0 write, then input 1 write back-to-back
//     -> HWDATA_OUT = HWDATA_IN[0] in cycle 2 and HWDATA_IN[1] in cycle 3.
//  T6 reset mid-burst: assert HRESETn=0 during beat 2 of an input 1 burst
//     -> own/dph/hold clear; after release, input 0 wins.

Source files
------------

// File: rtl/ahblite_busmatrix_outputstage_arb.sv
// ============================================================================
// Module  : ahblite_busmatrix_outputstage_arb
// Brief   : AHB-Lite bus-matrix output stage. Arbitrates one slave port among
//           three input stages and steers the data-phase write data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ahblite_busmatrix_outputstage_arb #(
  parameter int RR_EN = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  HSEL_IN,
  input  logic [5:0]  HTRANS_IN,
  input  logic [95:0] HADDR_IN,
  input  logic [2:0]  HWRITE_IN,
  input  logic [8:0]  HSIZE_IN,
  input  logic [95:0] HWDATA_IN,
  input  logic        HREADYOUT_S,
  output logic        HSEL_OUT,
  output logic [1:0]  HTRANS_OUT,
  output logic [31:0] HADDR_OUT,
  output logic        HWRITE_OUT,
  output logic [2:0]  HSIZE_OUT,
  output logic [31:0] HWDATA_OUT,
  output logic        HREADY_OUT,
  output logic [2:0]  ACTIVE_OUT
);

  localparam int         c_N           = 3;
  localparam logic [1:0] c_HTRANS_IDLE = 2'b00;
  localparam logic [1:0] c_HTRANS_BUSY = 2'b01;
  localparam logic [1:0] c_HTRANS_SEQ  = 2'b11;
  localparam logic [1:0] c_LAST_RST    = 2'd2;

  logic [1:0]  w_htrans [c_N];
  logic [31:0] w_haddr  [c_N];
  logic [2:0]  w_hsize  [c_N];
  logic [31:0] w_hwdata [c_N];
  logic [2:0]  w_req;

  logic [1:0]  r_own;
  logic        r_own_vld;
  logic        r_hold;
  logic [1:0]  r_last;
  logic [1:0]  r_dph;
  logic        r_dph_vld;

  logic [1:0]  w_arb_idx;
  logic        w_arb_vld;
  logic [1:0]  w_scan;
  logic        w_lock;
  logic [1:0]  w_own;
  logic        w_own_vld;
  logic        w_new_grant;

  generate
    for (genvar r = 0; r < c_N; r++) begin : g_unpack
      assign w_htrans[r] = HTRANS_IN[2*r +: 2];
      assign w_haddr[r]  = HADDR_IN[32*r +: 32];
      assign w_hsize[r]  = HSIZE_IN[3*r +: 3];
      assign w_hwdata[r] = HWDATA_IN[32*r +: 32];
      assign w_req[r]    = HSEL_IN[r] & HTRANS_IN[2*r+1];
    end
  endgenerate

  // Arbitration candidate: round-robin scans from the input after the last
  // new grant; fixed priority simply takes the lowest requesting index.
  always_comb begin
    w_arb_idx = 2'd0;
    w_arb_vld = 1'b0;
    w_scan    = r_last;
    if (RR_EN != 0) begin
      for (int k = 0; k < c_N; k++) begin
        w_scan = (w_scan == 2'd2) ? 2'd0 : w_scan + 2'd1;
        if (!w_arb_vld && w_req[w_scan]) begin
          w_arb_idx = w_scan;
          w_arb_vld = 1'b1;
        end
      end
    end else begin
      if (w_req[0]) begin
        w_arb_idx = 2'd0;
        w_arb_vld = 1'b1;
      end else if (w_req[1]) begin
        w_arb_idx = 2'd1;
        w_arb_vld = 1'b1;
      end else if (w_req[2]) begin
        w_arb_idx = 2'd2;
        w_arb_vld = 1'b1;
      end
    end
  end

  assign w_lock = r_own_vld & HSEL_IN[r_own] &
                  ((w_htrans[r_own] == c_HTRANS_BUSY) | (w_htrans[r_own] == c_HTRANS_SEQ));

  // Ownership is suppressed while reset is asserted so no grant leaks out.
  always_comb begin
    w_own       = 2'd0;
    w_own_vld   = 1'b0;
    w_new_grant = 1'b0;
    if (!HRESETn) begin
      w_own_vld = 1'b0;
    end else if (r_hold || w_lock) begin
      w_own     = r_own;
      w_own_vld = 1'b1;
    end else if (w_arb_vld) begin
      w_own       = w_arb_idx;
      w_own_vld   = 1'b1;
      w_new_grant = 1'b1;
    end
  end

  always_comb begin
    HSEL_OUT   = w_own_vld;
    HTRANS_OUT = c_HTRANS_IDLE;
    HADDR_OUT  = 32'd0;
    HWRITE_OUT = 1'b0;
    HSIZE_OUT  = 3'd0;
    ACTIVE_OUT = 3'd0;
    if (w_own_vld) begin
      HTRANS_OUT = w_htrans[w_own];
      HADDR_OUT  = w_haddr[w_own];
      HWRITE_OUT = HWRITE_IN[w_own];
      HSIZE_OUT  = w_hsize[w_own];
      ACTIVE_OUT = 3'b001 << w_own;
    end
  end

  assign HWDATA_OUT = r_dph_vld ? w_hwdata[r_dph] : 32'd0;
  assign HREADY_OUT = HREADYOUT_S;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_own     <= 2'd0;
      r_own_vld <= 1'b0;
      r_hold    <= 1'b0;
      r_last    <= c_LAST_RST;
      r_dph     <= 2'd0;
      r_dph_vld <= 1'b0;
    end else begin
      r_own     <= w_own;
      r_own_vld <= w_own_vld;
      r_hold    <= w_own_vld & ~HREADYOUT_S;
      if (w_new_grant) begin
        r_last <= w_own;
      end
      // Data-phase owner only advances when the slave completes a beat.
      if (HREADYOUT_S) begin
        r_dph_vld <= w_own_vld & HTRANS_OUT[1];
        r_dph     <= w_own;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahblite_busmatrix_outputstage_arb.sv
// ============================================================================
// Module  : tb_ahblite_busmatrix_outputstage_arb
// Brief   : Directed bench for the output-stage arbiter, round-robin and
//           fixed-priority instances driven from the same inputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahblite_busmatrix_outputstage_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [2:0]  HSEL_IN;
  logic [5:0]  HTRANS_IN;
  logic [95:0] HADDR_IN;
  logic [2:0]  HWRITE_IN;
  logic [8:0]  HSIZE_IN;
  logic [95:0] HWDATA_IN;
  logic        HREADYOUT_S;

  logic        rr_hsel, fp_hsel;
  logic [1:0]  rr_htrans, fp_htrans;
  logic [31:0] rr_haddr, fp_haddr;
  logic        rr_hwrite, fp_hwrite;
  logic [2:0]  rr_hsize, fp_hsize;
  logic [31:0] rr_hwdata, fp_hwdata;
  logic        rr_hready, fp_hready;
  logic [2:0]  rr_active, fp_active;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahblite_busmatrix_outputstage_arb #(.RR_EN(1)) u_dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_IN(HSEL_IN), .HTRANS_IN(HTRANS_IN),
    .HADDR_IN(HADDR_IN), .HWRITE_IN(HWRITE_IN), .HSIZE_IN(HSIZE_IN),
    .HWDATA_IN(HWDATA_IN), .HREADYOUT_S(HREADYOUT_S),
    .HSEL_OUT(rr_hsel), .HTRANS_OUT(rr_htrans), .HADDR_OUT(rr_haddr),
    .HWRITE_OUT(rr_hwrite), .HSIZE_OUT(rr_hsize), .HWDATA_OUT(rr_hwdata),
    .HREADY_OUT(rr_hready), .ACTIVE_OUT(rr_active)
  );

  ahblite_busmatrix_outputstage_arb #(.RR_EN(0)) u_dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_IN(HSEL_IN), .HTRANS_IN(HTRANS_IN),
    .HADDR_IN(HADDR_IN), .HWRITE_IN(HWRITE_IN), .HSIZE_IN(HSIZE_IN),
    .HWDATA_IN(HWDATA_IN), .HREADYOUT_S(HREADYOUT_S),
    .HSEL_OUT(fp_hsel), .HTRANS_OUT(fp_htrans), .HADDR_OUT(fp_haddr),
    .HWRITE_OUT(fp_hwrite), .HSIZE_OUT(fp_hsize), .HWDATA_OUT(fp_hwdata),
    .HREADY_OUT(fp_hready), .ACTIVE_OUT(fp_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    HRESETn     = 1'b0;
    HREADYOUT_S = 1'b1;
    HWRITE_IN   = 3'b000;
    HSIZE_IN    = 9'd0;
    for (int r = 0; r < 3; r++) begin
      HADDR_IN[32*r +: 32]  = 32'h1000_0000 + 32'(r);
      HWDATA_IN[32*r +: 32] = 32'hD000_0000 + 32'(r);
    end

    // T1: reset with every input requesting
    HSEL_IN   = 3'b111;
    HTRANS_IN = 6'b101010;
    @(posedge HCLK);
    @(negedge HCLK);
    chk("t1_rst_hsel", {31'd0, rr_hsel}, 32'd0);
    chk("t1_rst_active", {29'd0, rr_active}, 32'd0);
    chk("t1_rst_hwdata", rr_hwdata, 32'd0);
    chk("t1_rst_active_fp", {29'd0, fp_active}, 32'd0);
    nxt();
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("t1_first_active", {29'd0, rr_active}, 32'd1);
    chk("t1_first_active_fp", {29'd0, fp_active}, 32'd1);
    chk("t1_first_haddr", rr_haddr, 32'h1000_0000);
    chk("t1_first_htrans", {30'd0, rr_htrans}, 32'd2);

    // T2: rotation under steady triple request
    nxt(); @(negedge HCLK);
    chk("t2_rr_1", {29'd0, rr_active}, 32'd2);
    chk("t2_fp_1", {29'd0, fp_active}, 32'd1);
    chk("t2_hwdata_0", rr_hwdata, 32'hD000_0000);
    nxt(); @(negedge HCLK);
    chk("t2_rr_2", {29'd0, rr_active}, 32'd4);
    chk("t2_fp_2", {29'd0, fp_active}, 32'd1);
    chk("t2_haddr_2", rr_haddr, 32'h1000_0002);
    nxt(); @(negedge HCLK);
    chk("t2_rr_3", {29'd0, rr_active}, 32'd1);
    chk("t2_fp_3", {29'd0, fp_active}, 32'd1);
    nxt();
    HSEL_IN = 3'b000;
    @(negedge HCLK);
    chk("t2_idle_hsel", {31'd0, rr_hsel}, 32'd0);
    chk("t2_idle_htrans", {30'd0, rr_htrans}, 32'd0);
    chk("t2_idle_active", {29'd0, rr_active}, 32'd0);
    chk("t2_idle_hwdata", rr_hwdata, 32'hD000_0000);
    nxt(); @(negedge HCLK);
    chk("t2_idle_hwdata_clr", rr_hwdata, 32'd0);

    // T3: input 1 stalled by three wait states while input 0 requests
    nxt();
    HSEL_IN          = 3'b011;
    HTRANS_IN        = 6'b001010;
    HADDR_IN[63:32]  = 32'h4000_0104;
    HREADYOUT_S      = 1'b0;
    @(negedge HCLK);
    chk("t3_active_0", {29'd0, rr_active}, 32'd2);
    chk("t3_haddr_0", rr_haddr, 32'h4000_0104);
    chk("t3_hready", {31'd0, rr_hready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (i == 2) HREADYOUT_S = 1'b1;
      @(negedge HCLK);
      chk("t3_active_w", {29'd0, rr_active}, 32'd2);
      chk("t3_haddr_w", rr_haddr, 32'h4000_0104);
    end
    nxt();
    HSEL_IN = 3'b001;
    @(negedge HCLK);
    chk("t3_after_active", {29'd0, rr_active}, 32'd1);
    chk("t3_after_hwdata", rr_hwdata, 32'hD000_0001);

    // T4: input 2 burst NONSEQ,SEQ,BUSY,SEQ with input 0 pending
    nxt();
    HSEL_IN   = 3'b101;
    HTRANS_IN = 6'b100010;
    @(negedge HCLK);
    chk("t4_beat1", {29'd0, rr_active}, 32'd4);
    nxt();
    HTRANS_IN = 6'b110010;
    @(negedge HCLK);
    chk("t4_beat2", {29'd0, rr_active}, 32'd4);
    chk("t4_beat2_htrans", {30'd0, rr_htrans}, 32'd3);
    chk("t4_beat2_hwdata", rr_hwdata, 32'hD000_0002);
    nxt();
    HTRANS_IN = 6'b010010;
    @(negedge HCLK);
    chk("t4_beat3_busy", {29'd0, rr_active}, 32'd4);
    chk("t4_beat3_htrans", {30'd0, rr_htrans}, 32'd1);
    nxt();
    HTRANS_IN = 6'b110010;
    @(negedge HCLK);
    chk("t4_beat4", {29'd0, rr_active}, 32'd4);
    chk("t4_beat4_hwdata", rr_hwdata, 32'd0);
    nxt();
    HSEL_IN   = 3'b001;
    HTRANS_IN = 6'b000010;
    @(negedge HCLK);
    chk("t4_release", {29'd0, rr_active}, 32'd1);

    // T5: back-to-back writes from input 0 then input 1
    nxt();
    HSEL_IN   = 3'b000;
    HTRANS_IN = 6'b000000;
    nxt();
    HSEL_IN   = 3'b001;
    HTRANS_IN = 6'b000010;
    HWRITE_IN = 3'b011;
    HSIZE_IN  = {3'd0, 3'd2, 3'd1};
    @(negedge HCLK);
    chk("t5_c1_active", {29'd0, rr_active}, 32'd1);
    chk("t5_c1_hwrite", {31'd0, rr_hwrite}, 32'd1);
    chk("t5_c1_hsize", {29'd0, rr_hsize}, 32'd1);
    chk("t5_c1_hwdata", rr_hwdata, 32'd0);
    nxt();
    HSEL_IN   = 3'b010;
    HTRANS_IN = 6'b001000;
    @(negedge HCLK);
    chk("t5_c2_active", {29'd0, rr_active}, 32'd2);
    chk("t5_c2_hsize", {29'd0, rr_hsize}, 32'd2);
    chk("t5_c2_hwdata", rr_hwdata, 32'hD000_0000);
    nxt();
    HSEL_IN   = 3'b000;
    HTRANS_IN = 6'b000000;
    @(negedge HCLK);
    chk("t5_c3_hwdata", rr_hwdata, 32'hD000_0001);

    // T6: reset asserted during beat 2 of an input 1 burst
    nxt();
    HSEL_IN   = 3'b010;
    HTRANS_IN = 6'b001000;
    HWRITE_IN = 3'b000;
    @(negedge HCLK);
    chk("t6_beat1", {29'd0, rr_active}, 32'd2);
    nxt();
    HSEL_IN   = 3'b011;
    HTRANS_IN = 6'b001110;
    @(negedge HCLK);
    chk("t6_beat2", {29'd0, rr_active}, 32'd2);
    chk("t6_beat2_hwdata", rr_hwdata, 32'hD000_0001);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_active", {29'd0, rr_active}, 32'd0);
    chk("t6_rst_hsel", {31'd0, rr_hsel}, 32'd0);
    chk("t6_rst_hwdata", rr_hwdata, 32'd0);
    chk("t6_rst_active_fp", {29'd0, fp_active}, 32'd0);
    nxt();
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("t6_rel_active", {29'd0, rr_active}, 32'd1);
    chk("t6_rel_haddr", rr_haddr, 32'h1000_0000);
    chk("t6_rel_hwdata", rr_hwdata, 32'd0);
    chk("t6_rel_active_fp", {29'd0, fp_active}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
